// File: rtl/mmio_init_pkg.sv
// Shared types for the MMIO bus initiator: FSM state and queued command layout.
package mmio_init_pkg;

  localparam int MMIO_ADDR_W   = 21;
  localparam int MMIO_DATA_W   = 32;
  localparam int TXN_CNT_WIDTH = 16;

  typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_t;

  typedef struct packed {
    logic                   write;
    logic [MMIO_ADDR_W-1:0] addr;
    logic [MMIO_DATA_W-1:0] wdata;
  } mmio_cmd_t;

endpackage

// File: rtl/mmio_bus_initiator_fifo.sv
// Synchronous first-word-fall-through FIFO. Pushes are dropped when full and
// pops are ignored when empty, so callers may strobe without pre-gating.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage needs no reset; occupancy tracking below decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_bus_initiator.sv
// Bus-master bridge: queues streamed read/write commands and issues each as a
// single-cycle FPro MMIO transaction after winning the shared bus.
module mmio_bus_initiator
  import mmio_init_pkg::*;
#(
  parameter int ADDR_WIDTH = MMIO_ADDR_W,
  parameter int DATA_WIDTH = MMIO_DATA_W,
  parameter int CMD_DEPTH  = 4,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr,
  input  logic [DATA_WIDTH-1:0]    cmd_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     bus_req,
  input  logic                     bus_gnt,
  output logic                     mmio_cs,
  output logic                     mmio_read,
  output logic                     mmio_write,
  output logic [ADDR_WIDTH-1:0]    mmio_addr,
  output logic [DATA_WIDTH-1:0]    mmio_wr_data,
  input  logic [DATA_WIDTH-1:0]    mmio_rd_data,
  output logic                     busy,
  output logic [TXN_CNT_WIDTH-1:0] txn_count
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);

  state_t              state;
  logic                rdy_en;
  mmio_cmd_t           cmd_in, cmd_head;
  logic                cmd_full, cmd_empty, cmd_pop;
  logic [CAW:0]        cmd_count;
  logic [DATA_WIDTH-1:0] rsp_q;
  logic                rsp_full, rsp_empty, rsp_push;
  logic [RAW:0]        rsp_count;
  logic                eligible;

  assign cmd_in.write = cmd_write;
  assign cmd_in.addr  = MMIO_ADDR_W'(cmd_addr);
  assign cmd_in.wdata = MMIO_DATA_W'(cmd_wdata);

  // cmd_ready is held low until the first edge after reset release.
  assign cmd_ready = rdy_en && !cmd_full;
  assign rsp_valid = !rsp_empty;
  assign rsp_data  = rsp_empty ? '0 : rsp_q;
  assign busy      = (state != IDLE) || (cmd_count != '0);

  // Reads wait while the response FIFO is full so it can never overflow.
  assign eligible  = !cmd_empty && (cmd_head.write || rsp_count < (RAW+1)'(RSP_DEPTH));
  assign cmd_pop   = (state == XFER);
  assign rsp_push  = (state == XFER) && mmio_read && !rsp_full;

  sync_fifo #(.WIDTH($bits(mmio_cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (cmd_valid && cmd_ready),
    .wdata (cmd_in),
    .pop   (cmd_pop),
    .rdata (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (cmd_count)
  );

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (rsp_push),
    .wdata (mmio_rd_data),
    .pop   (rsp_valid && rsp_ready),
    .rdata (rsp_q),
    .full  (rsp_full),
    .empty (rsp_empty),
    .count (rsp_count)
  );

  // Marks the first cycle after reset release for cmd_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  // Bus FSM; all bus outputs are registered so strobes never glitch on inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      bus_req      <= 1'b0;
      mmio_cs      <= 1'b0;
      mmio_read    <= 1'b0;
      mmio_write   <= 1'b0;
      mmio_addr    <= '0;
      mmio_wr_data <= '0;
      txn_count    <= '0;
    end else begin
      case (state)
        IDLE: if (eligible) begin
          state   <= REQ;
          bus_req <= 1'b1;
        end
        REQ: if (bus_gnt) begin
          state        <= XFER;
          mmio_cs      <= 1'b1;
          mmio_write   <= cmd_head.write;
          mmio_read    <= !cmd_head.write;
          mmio_addr    <= ADDR_WIDTH'(cmd_head.addr);
          mmio_wr_data <= cmd_head.write ? DATA_WIDTH'(cmd_head.wdata) : '0;
        end
        XFER: begin
          // Grant is not re-checked here: the arbiter holds it while bus_req=1.
          state        <= GAP;
          bus_req      <= 1'b0;
          mmio_cs      <= 1'b0;
          mmio_read    <= 1'b0;
          mmio_write   <= 1'b0;
          mmio_addr    <= '0;
          mmio_wr_data <= '0;
          txn_count    <= txn_count + 1'b1;
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus_initiator.sv
// Directed bench for mmio_bus_initiator with a bus/response scoreboard.
module tb_mmio_bus_initiator;

  localparam int AW = 21;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          cmd_ready, rsp_valid, bus_req, mmio_cs, mmio_read, mmio_write, busy;
  logic          rsp_ready = 1'b1, bus_gnt = 1'b1;
  logic [DW-1:0] rsp_data, mmio_wr_data, mmio_rd_data;
  logic [AW-1:0] mmio_addr;
  logic [15:0]   txn_count;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [AW+DW:0] exp_txn [$];
  logic [DW-1:0]  exp_rsp [$];
  int             xfer_cyc [$];
  logic [AW+DW:0] e;
  logic [DW-1:0]  r;

  mmio_bus_initiator dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .bus_req(bus_req), .bus_gnt(bus_gnt),
    .mmio_cs(mmio_cs), .mmio_read(mmio_read), .mmio_write(mmio_write),
    .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data),
    .busy(busy), .txn_count(txn_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slot model: one fixed register, everything else returns a tagged address.
  function automatic logic [DW-1:0] slot_model(input logic [AW-1:0] a);
    return (a == 21'h00140) ? 32'h12345678 : {11'h2A5, a};
  endfunction
  assign mmio_rd_data = slot_model(mmio_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus and response scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset && mmio_cs) begin
      xfer_cyc.push_back(cyc);
      if (exp_txn.size() == 0) chk("unexpected_xfer", 64'(mmio_addr), 64'h1_0000_0000);
      else begin
        e = exp_txn.pop_front();
        chk("xfer_write",   64'(mmio_write),   64'(e[AW+DW]));
        chk("xfer_read",    64'(mmio_read),    64'(!e[AW+DW]));
        chk("xfer_addr",    64'(mmio_addr),    64'(e[AW+DW-1:DW]));
        chk("xfer_wr_data", 64'(mmio_wr_data), 64'(e[DW-1:0]));
        chk("xfer_req",     64'(bus_req),      64'd1);
      end
    end else begin
      chk("idle_strobes", 64'({mmio_cs, mmio_read, mmio_write, mmio_addr}), 64'd0);
      chk("idle_wr_data", 64'(mmio_wr_data), 64'd0);
    end
    if (rsp_valid && rsp_ready) begin
      if (exp_rsp.size() == 0) chk("unexpected_rsp", 64'(rsp_data), 64'h1_0000_0000);
      else begin
        r = exp_rsp.pop_front();
        chk("rsp_data", 64'(rsp_data), 64'(r));
      end
    end
  end

  task automatic push_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("push_timeout", 64'd0, 64'd1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    exp_txn.push_back({w, a, w ? d : 32'h0});
    if (!w) exp_rsp.push_back(slot_model(a));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int  n = 0;
    logic done = 1'b0;
    while (!done && n < 500) begin
      @(negedge clk); n++;
      done = !busy && !rsp_valid && exp_txn.size() == 0 && exp_rsp.size() == 0;
    end
    chk("idle_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_outputs", 64'({rsp_valid, bus_req, busy, mmio_cs, mmio_read, mmio_write}), 64'd0);
    chk("rst_txn", 64'(txn_count), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    reset = 1'b1;
    #1 chk("rel_cmd_ready_low", 64'(cmd_ready), 64'd0);
    @(posedge clk); #1;
    chk("rel_cmd_ready_high", 64'(cmd_ready), 64'd1);

    // Single write: strobe 3 cycles after accept
    push_cmd(1'b1, 21'h00A05, 32'h0000BEEF);
    @(negedge clk); chk("w_n1_cs", 64'(mmio_cs), 64'd0);
    @(negedge clk); chk("w_n2_req", 64'({bus_req, mmio_cs}), 64'b10);
    @(negedge clk); chk("w_n3_cs", 64'(mmio_cs), 64'd1);
    @(negedge clk); chk("w_txn", 64'(txn_count), 64'd1);
    chk("w_no_rsp", 64'({rsp_valid, bus_req}), 64'd0);
    wait_idle();

    // Single read: response visible the cycle after the strobe
    push_cmd(1'b0, 21'h00140, 32'h0);
    @(negedge clk); chk("r_n1_cs", 64'(mmio_cs), 64'd0);
    @(negedge clk); chk("r_n2_cs", 64'(mmio_cs), 64'd0);
    @(negedge clk); chk("r_n3_rd", 64'({mmio_cs, mmio_read, rsp_valid}), 64'b110);
    @(negedge clk); chk("r_n4_rsp", 64'({rsp_valid, rsp_data}), {31'd0, 1'b1, 32'h12345678});
    wait_idle();
    chk("r_txn", 64'(txn_count), 64'd2);

    // Burst into a full command FIFO
    xfer_cyc.delete();
    @(posedge clk); #1 bus_gnt = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(1'b1, 21'(32'h10 + i), 32'hA000_0000 + i);
    chk("burst_full", 64'(cmd_ready), 64'd0);
    @(posedge clk); #1 bus_gnt = 1'b1;
    push_cmd(1'b0, 21'h00014, 32'h0);
    wait_idle();
    chk("burst_n", 64'(xfer_cyc.size()), 64'd5);
    for (int i = 1; i < xfer_cyc.size(); i++)
      chk("burst_spacing", 64'(xfer_cyc[i] - xfer_cyc[i-1]), 64'd4);
    chk("burst_txn", 64'(txn_count), 64'd7);

    // Response backpressure
    xfer_cyc.delete();
    @(posedge clk); #1 rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_cmd(1'b0, 21'(32'h200 + i), 32'h0);
    repeat (20) @(negedge clk);
    chk("bp_xfers", 64'(xfer_cyc.size()), 64'd4);
    chk("bp_state", 64'({busy, bus_req, rsp_valid}), 64'b101);
    chk("bp_head", 64'(rsp_data), 64'(slot_model(21'h200)));
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_idle();
    chk("bp_xfers_all", 64'(xfer_cyc.size()), 64'd6);
    chk("bp_txn", 64'(txn_count), 64'd13);

    // Grant withheld
    @(posedge clk); #1 bus_gnt = 1'b0;
    push_cmd(1'b1, 21'h003FF, 32'hCAFE0001);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); chk("gnt_wait", 64'({bus_req, mmio_cs}), 64'b10);
    end
    @(posedge clk); #1 bus_gnt = 1'b1;
    @(negedge clk); chk("gnt_sample", 64'(mmio_cs), 64'd0);
    @(negedge clk); chk("gnt_xfer", 64'(mmio_cs), 64'd1);
    @(negedge clk); chk("gnt_gap", 64'({bus_req, mmio_cs}), 64'd0);
    wait_idle();
    chk("gnt_txn", 64'(txn_count), 64'd14);

    // Reset during a read transfer
    push_cmd(1'b0, 21'h00140, 32'h0);
    push_cmd(1'b1, 21'h00055, 32'h5555);
    begin
      int n = 0;
      @(negedge clk);
      while (!mmio_cs && n < 20) begin @(negedge clk); n++; end
      chk("mid_rst_reach_xfer", 64'(mmio_cs), 64'd1);
    end
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_strobes", 64'({mmio_cs, mmio_read, mmio_write, bus_req}), 64'd0);
    chk("mid_rst_flags", 64'({cmd_ready, rsp_valid, busy}), 64'd0);
    chk("mid_rst_txn", 64'(txn_count), 64'd0);
    exp_txn.delete();
    exp_rsp.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    #1 chk("mid_rel_ready_low", 64'(cmd_ready), 64'd0);
    @(posedge clk); #1;
    chk("mid_rel_ready_high", 64'(cmd_ready), 64'd1);
    chk("mid_rel_state", 64'({busy, rsp_valid, txn_count}), 64'd0);
    repeat (10) @(negedge clk);
    push_cmd(1'b1, 21'h00A06, 32'h00001234);
    wait_idle();
    chk("post_rst_txn", 64'(txn_count), 64'd1);

    chk("final_txn_q", 64'(exp_txn.size()), 64'd0);
    chk("final_rsp_q", 64'(exp_rsp.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mmio_bus_initiator.md
Name: mmio_bus_initiator

Overview:
- Bus-master counterpart to the MMIO controller/slot fabric: queues read/write commands from a streaming command port and issues them as single-cycle FPro bus transactions (mmio_cs/read/write/addr/wr_data).
- Returns read data on a streaming response port.
- Requests the bus via bus_req/bus_gnt so an external arbiter can share the FPro bus with the MicroBlaze MCS.
- Intended for a debug/host bridge (e.g. UART command path) driving the MMIO slots.

Parameters:
ADDR_WIDTH, 21, FPro MMIO address width
DATA_WIDTH, 32, FPro data width
CMD_DEPTH, 4, command FIFO entries (power of 2, ≥2)
RSP_DEPTH, 4, response FIFO entries (power of 2, ≥2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
cmd_valid  in  1  command offered
cmd_ready  out  1  command FIFO not full
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  target MMIO address
cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
rsp_valid  out  1  read data available
rsp_ready  in  1  consumer accepts read data
rsp_data  out  DATA_WIDTH  read data, in command order
bus_req  out  1  bus request to arbiter
bus_gnt  in  1  bus grant from arbiter
mmio_cs  out  1  FPro chip select
mmio_read  out  1  FPro read strobe
mmio_write  out  1  FPro write strobe
mmio_addr  out  ADDR_WIDTH  FPro address
mmio_wr_data  out  DATA_WIDTH  FPro write data
mmio_rd_data  in  DATA_WIDTH  FPro read data, valid in the strobe cycle
busy  out  1  state != IDLE or command FIFO non-empty
txn_count  out  16  completed transactions, wraps 0xFFFF→0

Behaviour:
- Reset (reset=0, asynchronous): both FIFOs emptied; state=IDLE; txn_count=0.
  - All outputs 0 during reset, except cmd_ready, which is 0 while reset is asserted and 1 from the first cycle after release.
  - Reset mid-transaction aborts it: strobes drop immediately, nothing is pushed to the response FIFO, and queued commands are lost.
- Command accept: cmd_valid && cmd_ready at a rising edge pushes {write, addr, wdata}.
  - cmd_ready = !cmd_full, from registered FIFO state.
  - No push when full, even if a pop occurs in the same cycle; the freed slot shows as cmd_ready=1 on the next cycle.
- Response port: rsp_valid = !rsp_empty; pop on rsp_valid && rsp_ready; data is in issue order.
- FSM states IDLE, REQ, XFER, GAP:
  - IDLE: eligible = cmd non-empty && (head is write || rsp_count < RSP_DEPTH). If eligible, go to REQ.
  - REQ: bus_req=1. Stay until bus_gnt=1 is sampled, then go to XFER. bus_req holds while waiting.
  - XFER: exactly one cycle with bus_req=1, mmio_cs=1, mmio_write=head.write, mmio_read=!head.write, mmio_addr=head.addr. mmio_wr_data=head.wdata for writes, 0 for reads.
    - At the closing edge: pop the command FIFO; on a read, push mmio_rd_data into the response FIFO; increment txn_count; go to GAP.
    - bus_gnt is not re-checked in XFER. The arbiter must not revoke the grant while bus_req=1 (bench assertion).
  - GAP: one idle cycle with bus_req=0, then IDLE. This lets the arbiter re-grant between transactions.
- Outside XFER: mmio_cs/read/write=0 and mmio_addr/mmio_wr_data=0. Strobes are decoded from the state register only, so they are glitch-free with respect to inputs.
- Minimum latency with bus_gnt held at 1:
  - Command accepted at edge N, so the FIFO is non-empty in cycle N+1 (IDLE).
  - REQ in N+2, XFER in N+3.
  - Read data visible on rsp_valid in N+4.
  - Sustained throughput: 1 transaction per 4 cycles.
- Read backpressure: a read at the head is held in IDLE while the response FIFO is full. The response FIFO therefore never overflows. A write at the head proceeds regardless of the response FIFO.
- Response push and pop in the same edge are both honoured; the count is unchanged.
- Ordering: strict FIFO, one outstanding transaction, no reordering.

Decomposition:
- Package mmio_init_pkg holds:
  - state_t enum {IDLE, REQ, XFER, GAP};
  - mmio_cmd_t packed struct {write, addr[ADDR_WIDTH], wdata[DATA_WIDTH]};
  - TXN_CNT_WIDTH=16.
- Sub-module sync_fifo (parameterised WIDTH, DEPTH):
  - async active-low reset;
  - outputs full, empty, count;
  - first-word-fall-through read data.
  - Instantiated twice: command FIFO (mmio_cmd_t) and response FIFO (DATA_WIDTH).

Test Plan:
- Single write: gnt=1, push write addr 0x00A05 data 0x0000BEEF. Expect one XFER cycle with cs=1, write=1, read=0, addr=0x00A05, wr_data=0xBEEF, 3 cycles after accept; txn_count=1; rsp_valid stays 0.
- Single read: slot model drives mmio_rd_data=0x12345678 when addr=0x00140. Expect read strobe 3 cycles after accept; rsp_valid=1 next cycle with rsp_data=0x12345678.
- Burst/full: push 5 commands with CMD_DEPTH=4. Expect cmd_ready=0 after the 4th, 5th accepted after the first pop, all 5 issued in order at 4-cycle spacing, txn_count=5.
- Response backpressure: rsp_ready=0, queue 6 reads. Expect exactly 4 XFERs, then FSM held in IDLE with busy=1. Release rsp_ready and expect the remaining 2 issued; all 6 responses returned in order.
- Grant withheld: bus_gnt=0 for 10 cycles with a command queued. Expect bus_req=1, mmio_cs=0 throughout; XFER 1 cycle after gnt rises; bus_req=0 in GAP.
- Reset mid-operation: assert reset=0 during XFER of a read. Expect strobes low immediately, no response pushed, FIFOs empty, txn_count=0, cmd_ready=1 the cycle after release.
